seg_disp_arbiter: RTL
=====================

SEG_DISP_ARBITER -- requirements
Module: seg_disp_arbiter

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 25_000_000, the minimum number of clk cycles a granted frame stays displayed before re-arbitration; legal range 1..2^32-1.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports req0, req1  input  1  display-request level from requester 0 / 1.
REQ-005 SHALL have ports hexs0, hexs1  input  32  eight 4-bit hex digits from requester 0 / 1.
REQ-006 SHALL have ports les0, les1  input  8  per-digit enables; points0, points1  input  8  per-digit decimal points.
REQ-007 SHALL have ports gnt0, gnt1  output  1  registered grant to requester 0 / 1; at most one high.
REQ-008 SHALL have ports drv_hexs  output  32, drv_les  output  8, drv_points  output  8  registered frame to the serial segment driver.
REQ-009 SHALL have port drv_load  output  1  one-cycle strobe: drv_* valid, start shifting.
REQ-010 SHALL have port drv_done  input  1  one-cycle pulse from driver: 64-bit shift complete.

Function
REQ-011 SHALL implement states IDLE, LOAD, XFER, HOLD.
REQ-012 IDLE: no req -> stay; any req -> pick winner, set its gnt, latch its hexs/les/points into drv_*, go LOAD, all on the same edge.
REQ-013 Winner: single requester wins outright; both requesting -> requester not served last wins (round-robin); last-served pointer updates on every grant.
REQ-014 LOAD: drv_load=1 for exactly this one cycle, then XFER unconditionally.
REQ-015 XFER: wait for drv_done; drv_done -> HOLD with hold counter cleared to 0; drv_done in any other state SHALL be ignored.
REQ-016 HOLD: counter increments each cycle; exit on the cycle the counter reaches HOLD_CYCLES-1, i.e. HOLD lasts exactly HOLD_CYCLES cycles.
REQ-017 HOLD exit: arbitrate per REQ-013 on current req levels; winner (same or other requester) -> re-latch drv_* from the winner, update gnt, go LOAD; no req -> clear gnt0/gnt1, go IDLE; drv_* retain last frame.
REQ-018 Same requester re-winning SHALL refresh the frame (new latch and new drv_load); gnt stays high with no low glitch.
REQ-019 Requester dropping req during LOAD/XFER/HOLD SHALL NOT abort; frame completes and hold expires normally.
REQ-020 drv_hexs/drv_les/drv_points SHALL change only on the grant edge, never during LOAD, XFER or HOLD.
REQ-021 Hold counter SHALL be 32 bits, SHALL NOT wrap within HOLD, reset to 0 on HOLD entry.
REQ-022 Latency: req rising in IDLE -> gnt and drv_* next edge; drv_load high the cycle after.

Reset
REQ-023 rst high SHALL immediately force IDLE, gnt0=gnt1=0, drv_load=0, drv_hexs=0, drv_les=0, drv_points=0, hold counter 0, last-served pointer = 1 (requester 0 wins first tie).
REQ-024 rst asserted mid-XFER or mid-HOLD SHALL abandon the frame; after release, pending drv_done pulses SHALL be ignored until a new LOAD.

Verification
REQ-025 Reset then req0=1, hexs0=32'h1234_5678, les0=8'hFF: gnt0=1 and drv_hexs=32'h1234_5678 one cycle later, drv_load pulse next cycle, single cycle wide.
REQ-026 HOLD_CYCLES=4, req0=req1=1 permanently, drv_done 10 cycles after each drv_load: grants alternate 0,1,0,1; each HOLD exactly 4 cycles; never both gnt high.
REQ-027 req1 only, held: after each hold, gnt1 stays high, drv_load re-pulses, drv_hexs tracks hexs1 changed during HOLD only at the next grant edge.
REQ-028 req0 dropped during XFER: frame completes, HOLD runs 4 cycles, then gnt0=0, IDLE, drv_hexs unchanged.
REQ-029 drv_done pulsed in IDLE and HOLD: no state change; rst mid-HOLD: all outputs zero immediately, next tie goes to requester 0.

Source files
------------

// File: rtl/seg_disp_arbiter.sv
// Two-requester arbiter in front of a serial seven-segment driver.
// A winning requester's frame is latched into drv_*, pushed to the driver
// with a one-cycle drv_load strobe, and then held on the display for
// HOLD_CYCLES cycles before the next arbitration. Ties are broken
// round-robin against whichever requester was served last.
module seg_disp_arbiter #(
    parameter int unsigned HOLD_CYCLES = 25_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] hexs0,
    input  logic [31:0] hexs1,
    input  logic [7:0]  les0,
    input  logic [7:0]  les1,
    input  logic [7:0]  points0,
    input  logic [7:0]  points1,
    output logic        gnt0,
    output logic        gnt1,
    output logic [31:0] drv_hexs,
    output logic [7:0]  drv_les,
    output logic [7:0]  drv_points,
    output logic        drv_load,
    input  logic        drv_done
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        XFER,
        HOLD
    } state_t;

    // Last counter value inside HOLD; reaching it ends the hold window.
    localparam logic [31:0] HOLD_LAST = 32'(HOLD_CYCLES - 1);

    state_t      state;
    logic [31:0] hold_cnt;
    logic        last_served;

    logic        any_req;
    logic        pick1;
    logic [31:0] win_hexs;
    logic [7:0]  win_les;
    logic [7:0]  win_points;

    // Choose the winner from the live request levels and mux its frame.
    // pick1 is high when requester 1 wins: it is alone, or both ask and
    // requester 0 was the one served last.
    always_comb begin
        any_req    = req0 | req1;
        pick1      = req1 & (~req0 | ~last_served);
        win_hexs   = pick1 ? hexs1   : hexs0;
        win_les    = pick1 ? les1    : les0;
        win_points = pick1 ? points1 : points0;
    end

    // Main controller: grant, latch the frame, strobe the driver, wait for
    // the shift to finish, then keep the frame up for the hold window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            drv_hexs    <= 32'd0;
            drv_les     <= 8'd0;
            drv_points  <= 8'd0;
            drv_load    <= 1'b0;
            hold_cnt    <= 32'd0;
            last_served <= 1'b1;
        end else begin
            drv_load <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt0        <= ~pick1;
                        gnt1        <= pick1;
                        drv_hexs    <= win_hexs;
                        drv_les     <= win_les;
                        drv_points  <= win_points;
                        last_served <= pick1;
                        state       <= LOAD;
                    end
                end
                LOAD: begin
                    drv_load <= 1'b1;
                    state    <= XFER;
                end
                XFER: begin
                    if (drv_done) begin
                        hold_cnt <= 32'd0;
                        state    <= HOLD;
                    end
                end
                HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        if (any_req) begin
                            gnt0        <= ~pick1;
                            gnt1        <= pick1;
                            drv_hexs    <= win_hexs;
                            drv_les     <= win_les;
                            drv_points  <= win_points;
                            last_served <= pick1;
                            state       <= LOAD;
                        end else begin
                            gnt0  <= 1'b0;
                            gnt1  <= 1'b0;
                            state <= IDLE;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 32'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
